// File: rtl/ovl_fire_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : ovl_fire_collector_if
// Brief    : Failure-log readout port (valid/ready with one log record).
// Revision : 1.0
// ============================================================================
interface ovl_fire_collector_if #(
  parameter int IDX_W    = 3,
  parameter int TS_WIDTH = 32
);
  logic                log_valid;
  logic                log_ready;
  logic [IDX_W-1:0]    log_index;
  logic [1:0]          log_kind;
  logic                log_multi;
  logic [TS_WIDTH-1:0] log_time;

  modport master (
    output log_valid,
    input  log_ready,
    output log_index,
    output log_kind,
    output log_multi,
    output log_time
  );

  modport slave (
    input  log_valid,
    output log_ready,
    input  log_index,
    input  log_kind,
    input  log_multi,
    input  log_time
  );
endinterface
`default_nettype wire

// File: rtl/ovl_fire_collector.sv
`default_nettype none
// ============================================================================
// Module   : ovl_fire_collector
// Brief    : Collects OVL checker fires into sticky bits, counters and a log.
// Revision : 1.0
// ============================================================================
module ovl_fire_collector #(
  parameter int NUM_CHECKERS = 8,
  parameter int CNT_WIDTH    = 16,
  parameter int TS_WIDTH     = 32,
  parameter int LOG_DEPTH    = 4,
  parameter int IDX_W        = (NUM_CHECKERS > 1) ? $clog2(NUM_CHECKERS) : 1
) (
  input  wire logic                    clk,
  input  wire logic                    reset_n,
  input  wire logic                    enable,
  input  wire logic                    clear,
  input  wire logic [NUM_CHECKERS-1:0] fire_2state,
  input  wire logic [NUM_CHECKERS-1:0] fire_xcheck,
  input  wire logic [NUM_CHECKERS-1:0] fire_cover,
  output logic [NUM_CHECKERS-1:0]      sticky_2state,
  output logic [NUM_CHECKERS-1:0]      sticky_xcheck,
  output logic [CNT_WIDTH-1:0]         fail_count,
  output logic [CNT_WIDTH-1:0]         cover_count,
  ovl_fire_collector_if.master         log,
  output logic                         overflow,
  output logic                         irq
);

  localparam int c_PTR_W = $clog2(LOG_DEPTH);

  localparam logic [NUM_CHECKERS-1:0] c_VEC_ONE = NUM_CHECKERS'(1);
  localparam logic [CNT_WIDTH-1:0]    c_CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]    c_CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [TS_WIDTH-1:0]     c_TS_ONE  = TS_WIDTH'(1);
  localparam logic [c_PTR_W-1:0]      c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_PTR_W:0]        c_CNT1    = (c_PTR_W+1)'(1);
  localparam logic [c_PTR_W:0]        c_DEPTH   = (c_PTR_W+1)'(LOG_DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0]    idx;
    logic [1:0]          kind;
    logic                multi;
    logic [TS_WIDTH-1:0] ts;
  } rec_t;

  logic [TS_WIDTH-1:0]     r_ts;
  logic [c_PTR_W-1:0]      r_wr_ptr;
  logic [c_PTR_W-1:0]      r_rd_ptr;
  logic [c_PTR_W:0]        r_count;
  rec_t                    r_mem [LOG_DEPTH];

  logic [NUM_CHECKERS-1:0] w_fail_vec;
  logic                    w_fail_cycle;
  logic                    w_cover_cycle;
  logic [IDX_W-1:0]        w_first_idx;
  logic [1:0]              w_first_kind;
  logic                    w_found;
  logic                    w_multi;
  rec_t                    w_rec;
  rec_t                    w_head;
  logic                    w_valid;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_drop;

  logic [NUM_CHECKERS-1:0] w_sticky2_nxt;
  logic [NUM_CHECKERS-1:0] w_stickyx_nxt;
  logic [CNT_WIDTH-1:0]    w_fail_nxt;
  logic [CNT_WIDTH-1:0]    w_cover_nxt;
  logic                    w_ovf_nxt;

  // Free-running timestamp, deliberately independent of enable and clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + c_TS_ONE;
    end
  end

  assign w_fail_vec    = fire_2state | fire_xcheck;
  assign w_fail_cycle  = enable && (|w_fail_vec);
  assign w_cover_cycle = enable && (|fire_cover);
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi       = |(w_fail_vec & (w_fail_vec - c_VEC_ONE));

  always_comb begin
    w_first_idx  = '0;
    w_first_kind = 2'b00;
    w_found      = 1'b0;
    for (int k = 0; k < NUM_CHECKERS; k++) begin
      if (!w_found && w_fail_vec[k]) begin
        w_first_idx  = IDX_W'(k);
        w_first_kind = {fire_xcheck[k], fire_2state[k]};
        w_found      = 1'b1;
      end
    end
  end

  assign w_rec.idx   = w_first_idx;
  assign w_rec.kind  = w_first_kind;
  assign w_rec.multi = w_multi;
  assign w_rec.ts    = r_ts;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == c_DEPTH);
  assign w_pop   = w_valid && log.log_ready && !clear;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_push  = w_fail_cycle && !clear && (!w_full || w_pop);
  assign w_drop  = w_fail_cycle && !clear && w_full && !w_pop;

  always_comb begin
    w_sticky2_nxt = sticky_2state;
    w_stickyx_nxt = sticky_xcheck;
    w_fail_nxt    = fail_count;
    w_cover_nxt   = cover_count;
    w_ovf_nxt     = overflow;
    if (clear) begin
      w_sticky2_nxt = '0;
      w_stickyx_nxt = '0;
      w_fail_nxt    = '0;
      w_cover_nxt   = '0;
      w_ovf_nxt     = 1'b0;
    end else begin
      if (enable) begin
        w_sticky2_nxt = sticky_2state | fire_2state;
        w_stickyx_nxt = sticky_xcheck | fire_xcheck;
      end
      if (w_fail_cycle && (fail_count != c_CNT_MAX)) begin
        w_fail_nxt = fail_count + c_CNT_ONE;
      end
      if (w_cover_cycle && (cover_count != c_CNT_MAX)) begin
        w_cover_nxt = cover_count + c_CNT_ONE;
      end
      if (w_drop) begin
        w_ovf_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_2state <= '0;
      sticky_xcheck <= '0;
      fail_count    <= '0;
      cover_count   <= '0;
      overflow      <= 1'b0;
      irq           <= 1'b0;
    end else begin
      sticky_2state <= w_sticky2_nxt;
      sticky_xcheck <= w_stickyx_nxt;
      fail_count    <= w_fail_nxt;
      cover_count   <= w_cover_nxt;
      overflow      <= w_ovf_nxt;
      // Built from next-state values so irq lines up with the sticky bits.
      irq           <= (|w_sticky2_nxt) | (|w_stickyx_nxt) | w_ovf_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT1;
        2'b01:   r_count <= r_count - c_CNT1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Record storage needs no reset; an empty FIFO masks the head outputs.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_rec;
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign log.log_valid = w_valid;
  assign log.log_index = w_valid ? w_head.idx   : '0;
  assign log.log_kind  = w_valid ? w_head.kind  : 2'b00;
  assign log.log_multi = w_valid ? w_head.multi : 1'b0;
  assign log.log_time  = w_valid ? w_head.ts    : '0;

endmodule
`default_nettype wire

// File: tb/tb_ovl_fire_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_ovl_fire_collector
// Brief    : Directed and randomized bench for ovl_fire_collector.
// Revision : 1.0
// ============================================================================
module tb_ovl_fire_collector;

  localparam int N    = 8;
  localparam int CW   = 8;
  localparam int TW   = 32;
  localparam int D    = 4;
  localparam int IW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic [N-1:0]  fire_2state = '0;
  logic [N-1:0]  fire_xcheck = '0;
  logic [N-1:0]  fire_cover = '0;
  logic [N-1:0]  sticky_2state;
  logic [N-1:0]  sticky_xcheck;
  logic [CW-1:0] fail_count;
  logic [CW-1:0] cover_count;
  logic          overflow;
  logic          irq;

  ovl_fire_collector_if #(.IDX_W(IW), .TS_WIDTH(TW)) lif ();

  ovl_fire_collector #(
    .NUM_CHECKERS(N), .CNT_WIDTH(CW), .TS_WIDTH(TW), .LOG_DEPTH(D), .IDX_W(IW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .clear         (clear),
    .fire_2state   (fire_2state),
    .fire_xcheck   (fire_xcheck),
    .fire_cover    (fire_cover),
    .sticky_2state (sticky_2state),
    .sticky_xcheck (sticky_xcheck),
    .fail_count    (fail_count),
    .cover_count   (cover_count),
    .log           (lif),
    .overflow      (overflow),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    int          kind;
    int          multi;
    logic [TW-1:0] ts;
  } rec_t;

  rec_t          m_q[$];
  logic [N-1:0]  m_s2;
  logic [N-1:0]  m_sx;
  int            m_fc;
  int            m_cc;
  bit            m_ovf;
  logic [TW-1:0] m_ts;
  int            n_checks = 0;
  int            n_errors = 0;
  logic [TW-1:0] saved_ts[6];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_s2 = '0; m_sx = '0; m_fc = 0; m_cc = 0; m_ovf = 1'b0; m_ts = '0;
  endtask

  // Reference behaviour of one rising edge, from the current inputs and state.
  task automatic model_step();
    bit           pop;
    logic [N-1:0] fv;
    rec_t         r;
    pop = (m_q.size() > 0) && lif.log_ready;
    if (clear) begin
      m_q.delete();
      m_s2 = '0; m_sx = '0; m_fc = 0; m_cc = 0; m_ovf = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (enable) begin
        fv = fire_2state | fire_xcheck;
        m_s2 = m_s2 | fire_2state;
        m_sx = m_sx | fire_xcheck;
        if (fv != '0) begin
          m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
          r.idx = 0;
          for (int k = N - 1; k >= 0; k--) if (fv[k]) r.idx = k;
          r.kind  = 2 * int'(fire_xcheck[r.idx]) + int'(fire_2state[r.idx]);
          r.multi = ($countones(fv) > 1) ? 1 : 0;
          r.ts    = m_ts;
          if (m_q.size() < D) m_q.push_back(r);
          else m_ovf = 1'b1;
        end
        if (fire_cover != '0) m_cc = (m_cc < CMAX) ? m_cc + 1 : CMAX;
      end
    end
    m_ts = m_ts + 1;
  endtask

  task automatic compare_all();
    check("sticky_2state", sticky_2state, m_s2);
    check("sticky_xcheck", sticky_xcheck, m_sx);
    check("fail_count", fail_count, m_fc);
    check("cover_count", cover_count, m_cc);
    check("overflow", overflow, m_ovf);
    check("irq", irq, (m_s2 != '0) || (m_sx != '0) || m_ovf);
    check("log_valid", lif.log_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("log_index", lif.log_index, m_q[0].idx);
      check("log_kind", lif.log_kind, m_q[0].kind);
      check("log_multi", lif.log_multi, m_q[0].multi);
      check("log_time", lif.log_time, m_q[0].ts);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s2"}, sticky_2state, 0);
    check({tag, "_sx"}, sticky_xcheck, 0);
    check({tag, "_fc"}, fail_count, 0);
    check({tag, "_cc"}, cover_count, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_irq"}, irq, 0);
    check({tag, "_valid"}, lif.log_valid, 0);
    check({tag, "_index"}, lif.log_index, 0);
    check({tag, "_kind"}, lif.log_kind, 0);
    check({tag, "_multi"}, lif.log_multi, 0);
    check({tag, "_time"}, lif.log_time, 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    lif.log_ready = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    enable  = 1'b1;
    model_reset();

    // Single 2-state fire at timestamp 10.
    while (m_ts != 10) cycle();
    fire_2state = 8'h04;
    cycle();
    fire_2state = '0;
    check("t1_sticky", sticky_2state, 8'h04);
    check("t1_fc", fail_count, 1);
    check("t1_irq", irq, 1);
    check("t1_valid", lif.log_valid, 1);
    check("t1_index", lif.log_index, 2);
    check("t1_kind", lif.log_kind, 2'b01);
    check("t1_multi", lif.log_multi, 0);
    check("t1_time", lif.log_time, 10);
    lif.log_ready = 1'b1;
    cycle();
    lif.log_ready = 1'b0;

    // Mixed kinds in one cycle: lowest failing checker is 3 (xcheck only).
    fire_2state = 8'h20;
    fire_xcheck = 8'h08;
    cycle();
    fire_2state = '0;
    fire_xcheck = '0;
    check("t2_index", lif.log_index, 3);
    check("t2_kind", lif.log_kind, 2'b10);
    check("t2_multi", lif.log_multi, 1);
    check("t2_fc", fail_count, 2);
    check("t2_sx", sticky_xcheck, 8'h08);

    // Six failures into a four-deep log with no consumer.
    do_clear();
    for (int i = 0; i < 6; i++) begin
      fire_2state = N'($urandom_range(1, 255));
      saved_ts[i] = m_ts;
      cycle();
    end
    fire_2state = '0;
    check("t3_ovf", overflow, 1);
    check("t3_fc", fail_count, 6);
    lif.log_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_drain_time", lif.log_time, saved_ts[i]);
      cycle();
    end
    lif.log_ready = 1'b0;
    check("t3_empty", lif.log_valid, 0);

    // Full FIFO with simultaneous push and pop.
    do_clear();
    for (int i = 0; i < 4; i++) begin
      fire_xcheck = N'($urandom_range(1, 255));
      cycle();
    end
    lif.log_ready = 1'b1;
    fire_2state = 8'h80;
    cycle();
    fire_2state = '0;
    fire_xcheck = '0;
    check("t4_ovf", overflow, 0);
    cnt = 0;
    for (int t = 0; t < 10 && lif.log_valid; t++) begin
      cnt++;
      cycle();
    end
    check("t4_occupancy", cnt, 4);
    lif.log_ready = 1'b0;

    // Cover counter saturation; covers never reach the log.
    do_clear();
    fire_cover = 8'h01;
    repeat (CMAX + 4) cycle();
    fire_cover = '0;
    check("t5_cc_sat", cover_count, CMAX);
    check("t5_valid", lif.log_valid, 0);

    // Clear beats a simultaneous fire.
    fire_2state = 8'h11;
    cycle();
    clear = 1'b1;
    fire_2state = 8'hFF;
    fire_xcheck = 8'h11;
    fire_cover  = 8'h01;
    cycle();
    clear = 1'b0;
    fire_2state = '0; fire_xcheck = '0; fire_cover = '0;
    check_all_zero("t6_clear");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      enable        = ($urandom_range(0, 9) != 0);
      fire_2state   = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      fire_xcheck   = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
      fire_cover    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      lif.log_ready = ($urandom_range(0, 2) == 0);
      clear         = ($urandom_range(0, 499) == 0);
      cycle();
    end
    clear = 1'b0; enable = 1'b1;
    fire_2state = '0; fire_xcheck = '0; fire_cover = '0;

    // Asynchronous reset in the middle of a drain.
    lif.log_ready = 1'b0;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      fire_2state = N'($urandom_range(1, 255));
      cycle();
    end
    fire_2state = '0;
    lif.log_ready = 1'b1;
    cycle();
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("t7_async_rst");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    lif.log_ready = 1'b0;
    repeat (3) cycle();
    fire_xcheck = 8'h40;
    cycle();
    fire_xcheck = '0;
    check("t7_index", lif.log_index, 6);
    check("t7_time", lif.log_time, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ovl_fire_collector.md
Name: ovl_fire_collector

Overview:
- Downstream consumer of the fire buses from a bank of OVL checker instances (assert/assume/cover, e.g. the next-event checkers).
- Per checker, it latches sticky failure status and counts failing and covered cycles.
- It logs each failing cycle, with checker index and cycle timestamp, into a small FIFO that is drained over a valid/ready port. It also raises a registered interrupt.
- Sits between the checker bank and the bench/debug readout logic.

Parameters:
NUM_CHECKERS, 8, number of checker fire inputs (>=1)
CNT_WIDTH, 16, width of fail_count and cover_count (saturating)
TS_WIDTH, 32, width of free-running cycle timestamp (wraps)
LOG_DEPTH, 4, failure-log FIFO depth (power of two, >=2)
IDX_W, derived: clog2(NUM_CHECKERS), minimum 1

Ports:
clk  input  1  sampling clock, rising edge
reset_n  input  1  asynchronous active-low reset
enable  input  1  when 0, fire inputs are ignored; timestamp still runs
clear  input  1  synchronous clear of sticky bits, counters, FIFO, overflow
fire_2state  input  NUM_CHECKERS  per-checker 2-state assertion fire
fire_xcheck  input  NUM_CHECKERS  per-checker X/Z-check fire
fire_cover  input  NUM_CHECKERS  per-checker cover fire
sticky_2state  output  NUM_CHECKERS  latched 2-state failures
sticky_xcheck  output  NUM_CHECKERS  latched X-check failures
fail_count  output  CNT_WIDTH  number of cycles with any 2-state/xcheck fire
cover_count  output  CNT_WIDTH  number of cycles with any cover fire
log_valid  output  1  log head entry valid
log_ready  input  1  consumer accepts head entry
log_index  output  IDX_W  lowest-index failing checker of the entry
log_kind  output  2  bit0 = 2-state fired, bit1 = xcheck fired (for log_index)
log_multi  output  1  more than one checker failed in that cycle
log_time  output  TS_WIDTH  timestamp of the failing cycle
overflow  output  1  sticky: a record was dropped because the FIFO was full
irq  output  1  registered OR of all sticky bits and overflow

Behaviour:
- Reset (reset_n low, async): every output is 0; the FIFO is empty; the timestamp is 0.
- Timestamp:
  - Increments every cycle out of reset and wraps at 2^TS_WIDTH.
  - Not affected by clear or enable.
- Failure cycle: enable=1 and |(fire_2state|fire_xcheck).
- Cover cycle: enable=1 and |fire_cover.
- Sticky bits:
  - sticky_x[k] sets on the clock after fire_x[k]=1 with enable=1.
  - Held until clear or reset.
- Counters:
  - fail_count increments once per failure cycle, regardless of how many checkers fire.
  - cover_count increments once per cover cycle.
  - Both saturate at all-ones and never wrap.
- Log record on a failure cycle:
  - index = lowest k with a 2-state or xcheck fire.
  - kind = {fire_xcheck[k], fire_2state[k]}.
  - multi = 1 if more than one checker's fire bits are set.
  - time = timestamp value in that cycle.
- Cover fires are never logged.
- FIFO:
  - First-word-fall-through. A record pushed into an empty FIFO shows log_valid=1 the next cycle.
  - Pop occurs when log_valid && log_ready.
  - Head outputs hold stable while log_valid=1 and log_ready=0.
  - Push when full: if a pop happens in the same cycle, the push succeeds and no drop occurs. Otherwise the record is dropped, overflow sets and stays set. Counters and sticky bits still update.
  - Records leave in push order. Occupancy never exceeds LOG_DEPTH.
- clear:
  - Next cycle, sticky bits, counters, overflow and FIFO are all zero/empty.
  - Takes priority over any fire or pop in the same cycle; that cycle's fires are discarded.
  - irq drops one cycle after clear.
- irq is registered from the next-state sticky/overflow values, so it rises in the same cycle the sticky bit is first visible.
- Reset asserted mid-operation empties the FIFO immediately; any log_valid handshake in progress is abandoned.
- enable=0: no sticky, counter, or FIFO push activity. Pops still proceed.

Test Plan:
- Reset, then fire_2state=8'h04 for 1 cycle at timestamp 10 -> next cycle: sticky_2state=8'h04, fail_count=1, irq=1, log_valid=1, log_index=2, log_kind=2'b01, log_multi=0, log_time=10.
- Same cycle fire_2state=8'h20, fire_xcheck=8'h08 -> log_index=3, log_kind=2'b10, log_multi=1, fail_count +1 (not +2), sticky_xcheck=8'h08.
- log_ready=0, 6 consecutive failure cycles with LOG_DEPTH=4 -> 4 entries retained in order, overflow=1, fail_count=6. Then log_ready=1 drains exactly the 4 oldest timestamps.
- FIFO full, push and pop in the same cycle -> no overflow, occupancy stays 4.
- fire_cover=8'h01 held for 2^CNT_WIDTH+3 cycles -> cover_count saturates at all-ones, log_valid stays 0.
- clear asserted together with a fire -> next cycle all sticky bits, counters, overflow, log_valid and irq are 0. Also: reset_n pulsed low mid-drain -> all outputs 0 asynchronously.
